switch_debounce8: RTL and testbench

SWITCH_DEBOUNCE8 -- requirements
Module: switch_debounce8

---
 rtl/switch_debounce8.sv | 112 +++++++++++
 tb/tb_switch_debounce8.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/switch_debounce8.sv
// Eight-channel slide-switch debouncer. Each channel synchronizes its raw
// input, then only accepts a new level after it has persisted for
// DEBOUNCE_CYCLES consecutive synchronized cycles. Edge pulses are registered
// together with the accepted level.

module switch_debounce8_lane #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count cycles the synchronized level disagrees with the accepted one;
  // any agreement clears the count, the terminal count accepts the new level.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == TERM) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, counter, accepted level and one-cycle edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;
  assign fall_o   = fall_q;
endmodule

module switch_debounce8 #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  input  logic       in4,
  input  logic       in5,
  input  logic       in6,
  input  logic       in7,
  output logic       out0,
  output logic       out1,
  output logic       out2,
  output logic       out3,
  output logic       out4,
  output logic       out5,
  output logic       out6,
  output logic       out7,
  output logic [7:0] rise,
  output logic [7:0] fall,
  output logic       changed
);
  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0] in_w, out_w;

  assign in_w = {in7, in6, in5, in4, in3, in2, in1, in0};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    switch_debounce8_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw_i    (in_w[g]),
      .stable_o (out_w[g]),
      .rise_o   (rise[g]),
      .fall_o   (fall[g])
    );
  end

  assign {out7, out6, out5, out4, out3, out2, out1, out0} = out_w;

  // Pulses are already registered, so this OR never sees the raw inputs.
  assign changed = |(rise | fall);
endmodule

// File: tb/tb_switch_debounce8.sv
// Bench for switch_debounce8 (DEBOUNCE_CYCLES=4): directed scenarios plus a
// random bouncing phase, checked against a sliding-window reference model.

module tb_switch_debounce8;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_v = 8'h00;
  logic       o0, o1, o2, o3, o4, o5, o6, o7;
  logic [7:0] rise, fall;
  logic       changed;
  logic [7:0] outs;

  int tests = 0;
  int fails = 0;

  // Reference model: an input level is accepted once the value seen through
  // the two-cycle synchronizer has differed from the accepted level on each
  // of the last D edges.
  logic [7:0] raw_q[$];
  logic [7:0] win_q[$];
  logic [7:0] m_out, m_rise, m_fall;

  switch_debounce8 #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .in4(in_v[4]), .in5(in_v[5]), .in6(in_v[6]), .in7(in_v[7]),
    .out0(o0), .out1(o1), .out2(o2), .out3(o3),
    .out4(o4), .out5(o5), .out6(o6), .out7(o7),
    .rise(rise), .fall(fall), .changed(changed)
  );

  assign outs = {o7, o6, o5, o4, o3, o2, o1, o0};

  always #5 clk = ~clk;

  task automatic model_reset();
    raw_q.delete();
    win_q.delete();
    m_out  = 8'h00;
    m_rise = 8'h00;
    m_fall = 8'h00;
  endtask

  task automatic model_edge();
    logic [7:0] all_diff;
    raw_q.push_back(in_v);
    if (raw_q.size() > 3) void'(raw_q.pop_front());
    m_rise = 8'h00;
    m_fall = 8'h00;
    if (raw_q.size() == 3) begin
      win_q.push_back(raw_q[0]);
      if (win_q.size() > D) void'(win_q.pop_front());
    end
    if (win_q.size() == D) begin
      all_diff = 8'hFF;
      foreach (win_q[k]) all_diff &= (win_q[k] ^ m_out);
      m_rise = all_diff & ~m_out;
      m_fall = all_diff & m_out;
      m_out  = m_out ^ all_diff;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("out", outs, m_out);
    check("rise", rise, m_rise);
    check("fall", fall, m_fall);
    check("changed", {7'b0, changed}, {7'b0, |(m_rise | m_fall)});
    check("rise_and_fall", rise & fall, 8'h00);
  endtask

  // One clock: drive, take the edge, update model, sample 1ns later.
  task automatic step(input logic [7:0] v);
    in_v = v;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int n_rise, n_fall, n_chg, rise_at;
    logic [7:0] cur;

    // Reset state
    model_reset();
    #3;
    check("rst_out", outs, 8'h00);
    check("rst_pulses", rise | fall, 8'h00);
    check("rst_changed", {7'b0, changed}, 8'h00);
    #9 rst_n = 1'b1;   // released at t=12, clear of the edge at 15

    // Clean step on in3
    for (int e = 1; e <= 9; e++) begin
      step(8'h08);
      check("step_out3", {7'b0, outs[3]}, {7'b0, (e >= 6)});
      check("step_rise", rise, (e == 6) ? 8'h08 : 8'h00);
      check("step_fall", fall, 8'h00);
    end

    // Three-cycle glitch on in5 must be ignored
    for (int e = 1; e <= 11; e++) begin
      step((e <= 3) ? 8'h28 : 8'h08);
      check("glitch_out5", {7'b0, outs[5]}, 8'h00);
      check("glitch_pulses", {rise | fall, changed} == 9'd0 ? 8'h00 : 8'h01, 8'h00);
    end

    // Bounce on in0: 1,0,1,1,0 then hold 1
    n_rise = 0; n_fall = 0; rise_at = 0;
    for (int e = 1; e <= 16; e++) begin
      case (e)
        1, 3, 4: step(8'h09);
        2, 5:    step(8'h08);
        default: step(8'h09);
      endcase
      if (rise[0]) begin n_rise++; rise_at = e; end
      if (fall[0]) n_fall++;
    end
    check("bounce_rise_cnt", 8'(n_rise), 8'd1);
    check("bounce_rise_edge", 8'(rise_at), 8'd11);
    check("bounce_fall_cnt", 8'(n_fall), 8'd0);

    // Return everything to 0, then 00 -> A5 in one cycle
    for (int e = 1; e <= 8; e++) step(8'h00);
    check("clear_out", outs, 8'h00);
    n_chg = 0;
    for (int e = 1; e <= 9; e++) begin
      step(8'hA5);
      if (changed) n_chg++;
      check("multi_out", outs, (e >= 6) ? 8'hA5 : 8'h00);
      check("multi_rise", rise, (e == 6) ? 8'hA5 : 8'h00);
    end
    check("multi_chg_cnt", 8'(n_chg), 8'd1);

    // Release in2
    for (int e = 1; e <= 9; e++) begin
      step(8'hA1);
      check("rel_fall", fall, (e == 6) ? 8'h04 : 8'h00);
      check("rel_out2", {7'b0, outs[2]}, {7'b0, (e < 6)});
    end

    // Async reset at count 2 of a pending in1 rise
    for (int e = 1; e <= 4; e++) step(8'hA3);
    check("pre_rst_out", outs, 8'hA1);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_out", outs, 8'h00);
    check("arst_rise", rise, 8'h00);
    check("arst_fall", fall, 8'h00);
    check("arst_changed", {7'b0, changed}, 8'h00);
    #3 rst_n = 1'b1;
    for (int e = 1; e <= 9; e++) begin
      step(8'hA3);
      check("post_rst_rise1", {7'b0, rise[1]}, {7'b0, (e == 6)});
      check("post_rst_rise", rise, (e == 6) ? 8'hA3 : 8'h00);
    end

    // Random bouncing inputs with an occasional async reset
    cur = 8'hA3;
    for (int i = 0; i < 800; i++) begin
      for (int b = 0; b < 8; b++)
        if ($urandom_range(0, 9) == 0) cur[b] = ~cur[b];
      if (i == 400) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rand_rst_out", outs, 8'h00);
        #2 rst_n = 1'b1;
      end
      step(cur);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound on run length
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
